// File: rtl/load_unit_pkg.sv
// Shared types and helpers for the byte-serial load unit.
package load_unit_pkg;

    localparam int WORD_W    = 32;
    localparam int REGADDR_W = 5;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [REGADDR_W-1:0] regaddr_t;

    // Decoded operation; only the L-type encodings are meaningful here.
    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LB  = 3'd1,
        OP_LH  = 3'd2,
        OP_LW  = 3'd3,
        OP_LBU = 3'd4,
        OP_LHU = 3'd5,
        OP_ADD = 3'd6
    } oper_t;

    localparam word_t ZERO_WORD = '0;

    // Bytes moved by a load; 0 marks an op this unit does not execute.
    function automatic logic [2:0] op_nbytes(oper_t op);
        case (op)
            OP_LB, OP_LBU: op_nbytes = 3'd1;
            OP_LH, OP_LHU: op_nbytes = 3'd2;
            OP_LW:         op_nbytes = 3'd4;
            default:       op_nbytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_unit_extend.sv
// Sign/zero extension of the assembled little-endian load word.
module load_extend
    import load_unit_pkg::*;
(
    input  oper_t op_i,
    input  word_t raw_i,
    output word_t data_o
);

    // Pick the width from the op and replicate the sign bit or zero-fill.
    always_comb begin
        data_o = raw_i;
        case (op_i)
            OP_LB:   data_o = {{24{raw_i[7]}}, raw_i[7:0]};
            OP_LBU:  data_o = {24'd0, raw_i[7:0]};
            OP_LH:   data_o = {{16{raw_i[15]}}, raw_i[15:0]};
            OP_LHU:  data_o = {16'd0, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: one load in flight, bytes read one at a time over a shared
// 8-bit read port, assembled little-endian and extended for writeback.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     flush_i,
    input  logic     in_valid_i,
    output logic     in_ready_o,
    input  oper_t    in_op_i,
    input  word_t    in_base_i,
    input  word_t    in_imm_i,
    input  regaddr_t in_rd_i,
    output logic     mem_req_o,
    input  logic     mem_gnt_i,
    output word_t    mem_addr_o,
    input  logic [7:0] mem_din_i,
    output logic     out_valid_o,
    input  logic     out_ready_i,
    output word_t    out_data_o,
    output regaddr_t out_rd_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    word_t                  ea_q, ea_d;
    oper_t                  op_q, op_d;
    regaddr_t               rd_q, rd_d;
    logic [2:0]             nbytes_q, nbytes_d;
    logic [2:0]             issue_cnt_q, issue_cnt_d;
    logic [2:0]             cap_cnt_q, cap_cnt_d;
    logic [MEM_LATENCY-1:0] trk_q, trk_d;
    word_t                  raw_q, raw_d;

    logic issue_fire;
    logic cap_fire;
    logic last_cap;

    assign issue_fire = (state_q == ISSUE) && mem_gnt_i;
    // Returns arrive in issue order, so the tail of the strobe shift marks
    // which cycle carries the next byte on mem_din.
    assign cap_fire   = trk_q[MEM_LATENCY-1];
    assign last_cap   = cap_fire && ((cap_cnt_q + 3'd1) == nbytes_q);

    assign in_ready_o  = (state_q == IDLE) && !flush_i;
    assign mem_req_o   = (state_q == ISSUE);
    assign mem_addr_o  = ea_q + 32'(issue_cnt_q);
    assign out_valid_o = (state_q == RESP);
    assign out_rd_o    = rd_q;

    load_extend u_ext (
        .op_i   (op_q),
        .raw_i  (raw_q),
        .data_o (out_data_o)
    );

    // Next-state: FSM, issue/capture counters, return tracker, byte assembly.
    always_comb begin
        state_d     = state_q;
        ea_d        = ea_q;
        op_d        = op_q;
        rd_d        = rd_q;
        nbytes_d    = nbytes_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        raw_d       = raw_q;

        trk_d    = '0;
        trk_d[0] = issue_fire;
        for (int i = 1; i < MEM_LATENCY; i++) trk_d[i] = trk_q[i-1];

        if (cap_fire) begin
            raw_d[{cap_cnt_q[1:0], 3'b000} +: 8] = mem_din_i;
            cap_cnt_d = cap_cnt_q + 3'd1;
        end

        case (state_q)
            IDLE: begin
                // Non-load ops are consumed silently.
                if (in_valid_i && op_nbytes(in_op_i) != 3'd0) begin
                    ea_d        = in_base_i + in_imm_i;
                    op_d        = in_op_i;
                    rd_d        = in_rd_i;
                    nbytes_d    = op_nbytes(in_op_i);
                    issue_cnt_d = '0;
                    cap_cnt_d   = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_fire) begin
                    issue_cnt_d = issue_cnt_q + 3'd1;
                    if ((issue_cnt_q + 3'd1) == nbytes_q) state_d = WAIT;
                end
            end
            WAIT: begin
                // Go straight to RESP on the cycle the final byte lands.
                if (last_cap || cap_cnt_q == nbytes_q) state_d = RESP;
            end
            RESP: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A mispredict drops the load and any bytes still in flight.
        if (flush_i) begin
            state_d = IDLE;
            trk_d   = '0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ea_q        <= ZERO_WORD;
            op_q        <= OP_NOP;
            rd_q        <= '0;
            nbytes_q    <= '0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            trk_q       <= '0;
            raw_q       <= ZERO_WORD;
        end else begin
            state_q     <= state_d;
            ea_q        <= ea_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            nbytes_q    <= nbytes_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            trk_q       <= trk_d;
            raw_q       <= raw_d;
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: vector table plus stall/flush/reset/grant sequences.
module tb_load_unit;
    import load_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic     rst, flush, out_ready;
    oper_t    in_op;
    word_t    in_base, in_imm;
    regaddr_t in_rd;

    logic       in_valid1, in_ready1, mem_req1, mem_gnt1, out_valid1;
    word_t      mem_addr1, out_data1;
    regaddr_t   out_rd1;
    logic [7:0] mem_din1;

    logic       in_valid3, in_ready3, mem_req3, mem_gnt3, out_valid3;
    word_t      mem_addr3, out_data3;
    regaddr_t   out_rd3;
    logic [7:0] mem_din3;

    load_unit #(.MEM_LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid1), .in_ready_o(in_ready1), .in_op_i(in_op),
        .in_base_i(in_base), .in_imm_i(in_imm), .in_rd_i(in_rd),
        .mem_req_o(mem_req1), .mem_gnt_i(mem_gnt1), .mem_addr_o(mem_addr1),
        .mem_din_i(mem_din1), .out_valid_o(out_valid1), .out_ready_i(out_ready),
        .out_data_o(out_data1), .out_rd_o(out_rd1)
    );

    load_unit #(.MEM_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
        .in_valid_i(in_valid3), .in_ready_o(in_ready3), .in_op_i(in_op),
        .in_base_i(in_base), .in_imm_i(in_imm), .in_rd_i(in_rd),
        .mem_req_o(mem_req3), .mem_gnt_i(mem_gnt3), .mem_addr_o(mem_addr3),
        .mem_din_i(mem_din3), .out_valid_o(out_valid3), .out_ready_i(out_ready),
        .out_data_o(out_data3), .out_rd_o(out_rd3)
    );

    // Memory image: 0x100..0x103 = 80 7F 01 FF, elsewhere the low address byte.
    function automatic logic [7:0] mem_byte(word_t a);
        case (a)
            32'h100: mem_byte = 8'h80;
            32'h101: mem_byte = 8'h7F;
            32'h102: mem_byte = 8'h01;
            32'h103: mem_byte = 8'hFF;
            default: mem_byte = a[7:0];
        endcase
    endfunction

    // Memory models: data valid exactly latency cycles after issue, junk otherwise.
    word_t a1, a3 [3];
    logic  v1;
    logic [2:0] v3;
    always @(posedge clk) begin
        v1 <= mem_req1 && mem_gnt1;
        a1 <= mem_addr1;
        v3 <= {v3[1:0], mem_req3 && mem_gnt3};
        a3[0] <= mem_addr3;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end
    assign mem_din1 = v1    ? mem_byte(a1)    : 8'hA5;
    assign mem_din3 = v3[2] ? mem_byte(a3[2]) : 8'hA5;

    // Issued-address logs.
    word_t q1[$], q3[$];
    always @(posedge clk) begin
        if (!rst && mem_req1 && mem_gnt1) q1.push_back(mem_addr1);
        if (!rst && mem_req3 && mem_gnt3) q3.push_back(mem_addr3);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        oper_t       op;
        word_t       base;
        word_t       imm;
        regaddr_t    rd;
        word_t       exp;
        int          lat;
        int          nb;
    } vec_t;

    vec_t vecs[7];

    // One load on dut1 with gnt=1 and out_ready=1: latency, data, rd, addresses.
    task automatic run_load(input vec_t v);
        int n;
        int lo;
        lo = q1.size();
        @(negedge clk);
        chk({v.name, " in_ready"}, 32'(in_ready1), 32'd1);
        in_op = v.op; in_base = v.base; in_imm = v.imm; in_rd = v.rd;
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid1 && n < 30);
        chk({v.name, " latency"}, 32'(n), 32'(v.lat));
        chk({v.name, " data"}, out_data1, v.exp);
        chk({v.name, " rd"}, 32'(out_rd1), 32'(v.rd));
        @(posedge clk);
        @(negedge clk);
        chk({v.name, " in_ready_after"}, 32'(in_ready1), 32'd1);
        chk({v.name, " n_addr"}, 32'(q1.size() - lo), 32'(v.nb));
        for (int i = 0; i < v.nb && lo + i < q1.size(); i++)
            chk({v.name, " addr"}, q1[lo+i], v.base + v.imm + 32'(i));
    endtask

    initial begin
        logic [6:0] pat;
        int n;
        int lo;

        vecs[0] = '{"lw_100",   OP_LW,  32'h100, 32'h0,        5'd5,  32'hFF017F80, 6, 4};
        vecs[1] = '{"lb_104m4", OP_LB,  32'h104, 32'hFFFFFFFC, 5'd1,  32'hFFFFFF80, 3, 1};
        vecs[2] = '{"lbu_104m4",OP_LBU, 32'h104, 32'hFFFFFFFC, 5'd2,  32'h00000080, 3, 1};
        vecs[3] = '{"lh_101",   OP_LH,  32'h100, 32'h1,        5'd3,  32'h0000017F, 4, 2};
        vecs[4] = '{"lhu_102",  OP_LHU, 32'h102, 32'h0,        5'd4,  32'h0000FF01, 4, 2};
        vecs[5] = '{"lh_102",   OP_LH,  32'h102, 32'h0,        5'd6,  32'hFFFFFF01, 4, 2};
        vecs[6] = '{"lw_wrap",  OP_LW,  32'hFFFFFFF0, 32'hE,   5'd31, 32'h0100FFFE, 6, 4};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_valid3 = 1'b0; mem_gnt1 = 1'b1; mem_gnt3 = 1'b0;
        in_op = OP_NOP; in_base = '0; in_imm = '0; in_rd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst in_ready",  32'(in_ready1),  32'd1);
        chk("rst mem_req",   32'(mem_req1),   32'd0);
        chk("rst mem_addr",  mem_addr1,       32'd0);
        chk("rst out_valid", 32'(out_valid1), 32'd0);
        chk("rst out_data",  out_data1,       32'd0);
        chk("rst out_rd",    32'(out_rd1),    32'd0);

        foreach (vecs[i]) run_load(vecs[i]);

        // Non-load op is consumed with no memory traffic and no response.
        @(negedge clk);
        in_op = OP_ADD; in_valid1 = 1'b1;
        @(posedge clk); #1 in_valid1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("nonload in_ready",  32'(in_ready1),  32'd1);
            chk("nonload mem_req",   32'(mem_req1),   32'd0);
            chk("nonload out_valid", 32'(out_valid1), 32'd0);
        end

        // Grant gaps with MEM_LATENCY=3.
        lo = q3.size();
        @(negedge clk);
        in_op = OP_LW; in_base = 32'h100; in_imm = '0; in_rd = 5'd7;
        in_valid3 = 1'b1;
        @(posedge clk); #1 in_valid3 = 1'b0;
        pat = 7'b1101001;
        for (int k = 0; k < 7; k++) begin
            mem_gnt3 = pat[k];
            @(posedge clk); #1;
        end
        mem_gnt3 = 1'b1;
        n = 0;
        while (!out_valid3 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("gnt3 out_valid", 32'(out_valid3), 32'd1);
        chk("gnt3 data", out_data3, 32'hFF017F80);
        chk("gnt3 rd", 32'(out_rd3), 32'd7);
        chk("gnt3 n_addr", 32'(q3.size() - lo), 32'd4);
        for (int i = 0; i < 4 && lo + i < q3.size(); i++)
            chk("gnt3 addr", q3[lo+i], 32'h100 + 32'(i));
        @(posedge clk); @(negedge clk);
        mem_gnt3 = 1'b0;

        // Writeback stall: result and rd hold, no new load accepted.
        out_ready = 1'b0;
        @(negedge clk);
        in_op = OP_LB; in_base = 32'h100; in_imm = '0; in_rd = 5'd9;
        in_valid1 = 1'b1;
        @(posedge clk); #1 in_valid1 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid1 && n < 30);
        for (int k = 0; k < 3; k++) begin
            chk("stall out_valid", 32'(out_valid1), 32'd1);
            chk("stall data",      out_data1,       32'hFFFFFF80);
            chk("stall rd",        32'(out_rd1),    32'd9);
            chk("stall in_ready",  32'(in_ready1),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("stall release out_valid", 32'(out_valid1), 32'd0);
        chk("stall release in_ready",  32'(in_ready1),  32'd1);

        // Flush in WAIT, then a fresh LB must return only its own data.
        in_op = OP_LW; in_base = 32'h100; in_imm = '0; in_rd = 5'd10;
        in_valid1 = 1'b1;
        @(posedge clk); #1 in_valid1 = 1'b0;
        repeat (5) @(negedge clk);
        chk("flush wait mem_req",   32'(mem_req1),   32'd0);
        chk("flush wait out_valid", 32'(out_valid1), 32'd0);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush out_valid", 32'(out_valid1), 32'd0);
            chk("flush mem_req",   32'(mem_req1),   32'd0);
            chk("flush in_ready",  32'(in_ready1),  32'd1);
        end
        run_load('{"lb_after_flush", OP_LB, 32'h100, 32'h0, 5'd11, 32'hFFFFFF80, 3, 1});

        // Reset during ISSUE.
        @(negedge clk);
        in_op = OP_LW; in_base = 32'h100; in_imm = '0; in_rd = 5'd12;
        in_valid1 = 1'b1;
        @(posedge clk); #1 in_valid1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_issue mem_req_before", 32'(mem_req1), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_issue mem_req",   32'(mem_req1),   32'd0);
        chk("rst_issue in_ready",  32'(in_ready1),  32'd1);
        chk("rst_issue mem_addr",  mem_addr1,       32'd0);
        chk("rst_issue out_valid", 32'(out_valid1), 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("rst_issue quiet", 32'(out_valid1), 32'd0);
        end
        run_load(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
